// File: rtl/matrix_codec_pkg.sv
// Shared definitions for the 5x5 slice-matrix encoder/decoder pair.
// Bit index of a line is 5*y+x; both sides must use these helpers.
package matrix_codec_pkg;

    localparam int WIDTH    = 25;
    localparam int LINES    = 64;
    localparam int CNT_W    = 7;
    localparam int ADDR_W   = 7;
    localparam int OUT_BASE = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } dec_state_t;

    // Column parity: bit x is the XOR of the five bits in column x.
    function automatic logic [4:0] col_parity(input logic [WIDTH-1:0] line);
        logic [4:0] par;
        par = '0;
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                par[x] = par[x] ^ line[5*y+x];
            end
        end
        return par;
    endfunction

    // Mask applied to every row: neighbour columns (x-1) and (x+1) mod 5.
    function automatic logic [WIDTH-1:0] parity_spread(input logic [4:0] par);
        logic [WIDTH-1:0] mask;
        mask = '0;
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                mask[5*y+x] = par[(x+4)%5] ^ par[(x+1)%5];
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/matrix_decoder_ctrl.sv
// Sequencer for the decoder: walks the 64 lines with a read/wait/write
// cadence and produces the memory strobes plus datapath enables.
module matrix_decoder_ctrl
    import matrix_codec_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              accept,
    output logic              capture
);

    dec_state_t       state_reg;
    dec_state_t       state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             last_line;

    assign last_line = (cnt_reg == CNT_W'(LINES - 1));

    // State and line counter; counter clears when a run is accepted and
    // holds at the terminal value so it can never wrap mid-run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                cnt_reg <= '0;
            end else if (state_reg == ST_WRITE && !last_line) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    // Next-state and strobe decode; start only matters in IDLE.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b1;
        done       = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_READ;
                end
            end
            ST_READ: begin
                mem_rd     = 1'b1;
                mem_addr   = ADDR_W'(cnt_reg);
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                capture    = 1'b1;
                state_next = ST_WRITE;
            end
            ST_WRITE: begin
                mem_wr     = 1'b1;
                mem_addr   = ADDR_W'(OUT_BASE) + ADDR_W'(cnt_reg);
                state_next = last_line ? ST_DONE : ST_READ;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/matrix_decoder.sv
// Matrix decoder top: undoes the column-parity mixing line by line using
// the previously decoded line, reading words 0..63 and writing 64..127.
module matrix_decoder
    import matrix_codec_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic              mem_wr,
    output logic [WIDTH-1:0]  mem_wdata
);

    logic             accept;
    logic             capture;
    logic [WIDTH-1:0] prev_reg;
    logic [WIDTH-1:0] hold_reg;
    logic [WIDTH-1:0] decoded_next;

    matrix_decoder_ctrl u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .accept   (accept),
        .capture  (capture)
    );

    // Strip the mask derived from the previous line's column parity.
    assign decoded_next = mem_rdata ^ parity_spread(col_parity(prev_reg));

    // Holding register keeps write data stable through WRITE; prev tracks
    // the last decoded line and restarts from zero for every run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_reg <= '0;
            hold_reg <= '0;
        end else begin
            if (accept) begin
                prev_reg <= '0;
            end else if (mem_wr) begin
                prev_reg <= hold_reg;
            end
            if (capture) begin
                hold_reg <= decoded_next;
            end
        end
    end

    assign mem_wdata = mem_wr ? hold_reg : '0;

endmodule

// File: tb/tb_matrix_decoder.sv
// Self-checking bench for matrix_decoder: memory model, line encoder
// reference and a write/done monitor with cycle-accurate timing checks.
module tb_matrix_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        done;
    logic        busy;
    logic [6:0]  mem_addr;
    logic        mem_rd;
    logic [24:0] mem_rdata = '0;
    logic        mem_wr;
    logic [24:0] mem_wdata;

    logic [24:0] src [64];
    logic [24:0] out_mem [64];
    logic [24:0] exp_d [64];
    logic [24:0] d_ref [64];
    logic        clear_out = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_cnt = 0;
    int start_edge = 0;
    int wr_idx = 0;
    int done_cnt = 0;
    int done_rel = 0;
    bit run_active = 1'b0;

    matrix_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .done      (done),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Shared line memory: encoded input in words 0..63, output in 64..127.
    always @(posedge clk) begin
        if (clear_out) begin
            for (int i = 0; i < 64; i++) out_mem[i] <= 25'h0AAAAAA;
        end else if (mem_wr && mem_addr >= 7'd64) begin
            out_mem[mem_addr[5:0]] <= mem_wdata;
        end
        if (mem_rd) begin
            mem_rdata <= (mem_addr < 7'd64) ? src[mem_addr[5:0]] : out_mem[mem_addr[5:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference encoder straight from the encoding rule.
    function automatic void encode_lines();
        logic [4:0] cp;
        logic [4:0] c;
        cp = '0;
        for (int z = 0; z < 64; z++) begin
            c = '0;
            for (int y = 0; y < 5; y++)
                for (int x = 0; x < 5; x++)
                    c[x] = c[x] ^ d_ref[z][5*y+x];
            for (int y = 0; y < 5; y++)
                for (int x = 0; x < 5; x++)
                    src[z][5*y+x] = d_ref[z][5*y+x] ^ cp[(x+4)%5] ^ cp[(x+1)%5];
            cp = c;
        end
    endfunction

    // Observes every write and done pulse during a run.
    always @(negedge clk) begin
        int rel;
        if (run_active) begin
            rel = edge_cnt - start_edge;
            if (mem_wr) begin
                if (wr_idx < 64) begin
                    check("wr_addr", 32'(mem_addr), 32'(64 + wr_idx));
                    check("wr_data", 32'(mem_wdata), 32'(exp_d[wr_idx]));
                    check("wr_cycle", 32'(rel + 1), 32'(3 * wr_idx + 3));
                end else begin
                    check("wr_extra", 32'(wr_idx), 32'd63);
                end
                wr_idx++;
            end
            if (done) begin
                done_cnt++;
                done_rel = rel + 1;
            end
        end
    end

    task automatic clear_region();
        @(negedge clk);
        clear_out = 1'b1;
        @(negedge clk);
        clear_out = 1'b0;
    endtask

    task automatic check_region(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (out_mem[i] !== exp_d[i]) bad++;
            check("region", 32'(out_mem[i]), 32'(exp_d[i]));
        end
        $display("[TB] %s: output region compared, %0d words differ", name, bad);
    endtask

    task automatic run_decode(input bit hold, input bit chained, input bit pulses, input int abort_at);
        int  rel;
        bit  finished;
        finished = 1'b0;
        if (chained) begin
            @(posedge clk);
            @(negedge clk);
        end else begin
            @(negedge clk);
            start = 1'b1;
        end
        wr_idx   = 0;
        done_cnt = 0;
        done_rel = 0;
        @(posedge clk);
        #1;
        start_edge = edge_cnt;
        run_active = 1'b1;
        if (!hold) start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            #1;
            rel = edge_cnt - start_edge;
            if (pulses) start = (rel == 10 || rel == 50);
            if (abort_at > 0 && rel == abort_at) begin
                check("pre_rst_wr", 32'(mem_wr), 32'd1);
                rst = 1'b0;
                #1;
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_rd", 32'(mem_rd), 32'd0);
                check("rst_wr", 32'(mem_wr), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                check("rst_addr", 32'(mem_addr), 32'd0);
                check("rst_wdata", 32'(mem_wdata), 32'd0);
                run_active = 1'b0;
                $display("[TB] reset asserted at run cycle %0d after %0d writes", rel, wr_idx);
                repeat (2) @(negedge clk);
                rst = 1'b1;
                return;
            end
            if (done_cnt > 0) begin
                finished = 1'b1;
                break;
            end
        end
        if (!finished) begin
            check("timeout", 32'd0, 32'd1);
        end else begin
            check("writes", 32'(wr_idx), 32'd64);
            check("done_cycle", 32'(done_rel), 32'd193);
        end
        if (!hold) begin
            repeat (4) @(negedge clk);
            #1;
            check("done_count", 32'(done_cnt), 32'd1);
            check("idle_busy", 32'(busy), 32'd0);
        end
        $display("[TB] run: %0d writes, done at cycle %0d, %0d done pulses", wr_idx, done_rel, done_cnt);
        run_active = 1'b0;
    endtask

    task automatic random_lines();
        for (int i = 0; i < 64; i++) begin
            d_ref[i] = 25'($urandom);
            exp_d[i] = d_ref[i];
        end
        encode_lines();
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            src[i]   = '0;
            exp_d[i] = '0;
        end
        repeat (3) @(negedge clk);
        check("reset_done", 32'(done), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rd", 32'(mem_rd), 32'd0);
        check("reset_wr", 32'(mem_wr), 32'd0);
        check("reset_addr", 32'(mem_addr), 32'd0);
        check("reset_wdata", 32'(mem_wdata), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_start0_busy", 32'(busy), 32'd0);

        // All-zero encoded memory decodes to all zero.
        clear_region();
        run_decode(1'b0, 1'b0, 1'b0, 0);
        check_region("all_zero");

        // All-ones lines: parity cancels, output equals input.
        for (int i = 0; i < 64; i++) begin
            src[i]   = 25'h1FFFFFF;
            exp_d[i] = 25'h1FFFFFF;
        end
        clear_region();
        run_decode(1'b0, 1'b0, 1'b0, 0);
        check_region("all_ones");

        // Single bit whose mask is exactly cancelled by line 1.
        for (int i = 0; i < 64; i++) begin
            src[i]   = '0;
            exp_d[i] = '0;
        end
        src[0]   = 25'h0000001;
        src[1]   = 25'h1294A52;
        exp_d[0] = 25'h0000001;
        clear_region();
        run_decode(1'b0, 1'b0, 1'b0, 0);
        check_region("single_bit");

        // Random data, two back-to-back runs with start held high.
        random_lines();
        clear_region();
        run_decode(1'b1, 1'b0, 1'b0, 0);
        run_decode(1'b1, 1'b1, 1'b0, 0);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("b2b_idle", 32'(busy), 32'd0);
        check_region("random_b2b");

        // Start pulses mid-run must be ignored.
        random_lines();
        clear_region();
        run_decode(1'b0, 1'b0, 1'b1, 0);
        check_region("start_pulses");

        // Reset mid-run, then a fresh run from line 0.
        random_lines();
        run_decode(1'b0, 1'b0, 1'b0, 101);
        random_lines();
        run_decode(1'b0, 1'b0, 1'b0, 0);
        check_region("after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
